if_id_decode: RTL and testbench
===============================

Name: if_id_decode

Overview:
- Fetch/decode pipeline stage directly downstream of the instruction memory.
- Registers the 32-bit instruction word and splits it into MIPS fields.
- Generates datapath control signals and returns imm16 and the branch request to the program counter.
- Supports stall, flush, optional post-branch squash, and counts decoded instructions.

Parameters:
- SQUASH_BR, 1, when 1 the instruction accepted right after a branch is dropped (branch shadow); when 0 no squash.
- CNT_W, 16, width of the decoded-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- inst  in  32  instruction word from instruction memory
- inst_valid  in  1  inst is meaningful this cycle
- stall  in  1  hold stage contents
- flush  in  1  discard stage contents
- valid  out  1  decoded outputs are meaningful
- opcode  out  6  inst[31:26]
- rs  out  5  inst[25:21]
- rt  out  5  inst[20:16]
- rd  out  5  inst[15:11]
- shamt  out  5  inst[10:6]
- funct  out  6  inst[5:0]
- imm16  out  16  inst[15:0], to the program counter
- reg_dst  out  1  1 = write rd, 0 = write rt
- alu_src  out  1  1 = immediate operand
- ext_op  out  1  1 = sign-extend imm16, 0 = zero-extend
- alu_ctr  out  4  ALU operation code
- mem_to_reg  out  1  load result selects writeback
- mem_wr  out  1  store
- reg_wr  out  1  register write enable
- br_type  out  2  00 none, 01 beq, 10 bne, 11 bgtz
- pc_sel  out  1  branch instruction present (valid & br_type != 00)
- illegal  out  1  unsupported opcode/funct
- dec_count  out  CNT_W  number of valid instructions decoded

Behaviour:
- Reset (rst_n low at a clk edge):
  - All outputs are 0; FSM state is RUN; dec_count is 0.
  - Reset mid-squash returns the FSM to RUN.
- Latency: an instruction accepted at edge N (inst_valid=1, stall=0, flush=0) has its decoded outputs visible after edge N.
  - valid=1 for one cycle unless it is held by stall.
- Priority, highest first: rst_n, then flush, then stall, then accept.
  - flush: valid=0, all control outputs 0, FSM to RUN.
  - stall: every register and the FSM state hold, including dec_count.
  - inst_valid=0 with no stall: valid=0 and controls 0. Field outputs may update.
- FSM states:
  - RUN: accepting a branch with SQUASH_BR=1 moves to SQUASH.
  - SQUASH: the next accepted instruction produces valid=0, controls 0 and no count, then the FSM returns to RUN. inst_valid=0 cycles stay in SQUASH.
- Supported decode:
  - R-type (op 00): add 20, addu 21, sub 22, subu 23, and 24, or 25, slt 2A, sltu 2B, sll 00.
    - reg_dst=1, reg_wr=1.
  - addi 08, addiu 09: alu_src=1, ext_op=1, reg_wr=1.
  - ori 0D: alu_src=1, ext_op=0, reg_wr=1.
  - lw 23: alu_src=1, ext_op=1, mem_to_reg=1, reg_wr=1.
  - sw 2B: alu_src=1, ext_op=1, mem_wr=1.
  - beq 04, bne 05, bgtz 07: br_type set, ext_op=1, alu_ctr=SUB.
- Register-write rules:
  - reg_wr is forced 0 when the destination register is 0, so 0x00000000 is a NOP with valid=1.
  - Any other opcode/funct sets illegal=1 and all other controls to 0 (see optional feature).
- dec_count increments by 1 on each edge that sets valid=1 from an accept, including illegal instructions. It wraps modulo 2^CNT_W.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined:
  - illegal becomes sticky; it clears only on reset.
  - While sticky, the stage acts as permanently flushed (valid=0, no count).
- Undefined:
  - illegal is per-instruction.
  - The instruction passes as a NOP with valid=1 and is counted.

Decomposition:
- Package cpu_pkg holds:
  - Opcode and funct constants.
  - ALU codes: ADD=0010, SUB=0110, AND=0000, OR=0001, SLT=0111, SLTU=1111, SLL=0011.
  - br_type encodings.
  - FSM state encoding.
- Sub-module ctrl_decode: purely combinational, mapping opcode/funct to the control bundle. The register and FSM stay in if_id_decode.

Test Plan:
- Reset: rst_n=0 for 2 cycles with inst=0x8C220004 → valid=0, all outputs 0, dec_count=0.
- lw: accept 0x8C220004 → next cycle valid=1, rs=1, rt=2, imm16=0004, alu_src=1, mem_to_reg=1, reg_wr=1, reg_dst=0, dec_count=1.
- add with stall: accept 0x00221820, then stall for 3 cycles → rd=3, funct=20, alu_ctr=0010, reg_dst=1; outputs and dec_count unchanged during the stall.
- Branch squash (SQUASH_BR=1): accept 0x10220003 then 0x34030005 → first gives pc_sel=1, br_type=01, imm16=0003; second gives valid=0; a third instruction decodes normally.
- flush with stall: flush=1 and stall=1 together while holding ori → valid=0, controls 0 on the next edge.
- Illegal: accept 0xFC000000 then 0x8C220004 → illegal=1. Without ILLEGAL_TRAP_EN, the lw decodes with valid=1. With ILLEGAL_TRAP_EN, valid stays 0 until reset.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the fetch/decode stage: opcodes, functs, ALU codes,
// branch types, FSM states and the packed control bundle.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL    = 6'h00;
  localparam logic [5:0] F_ADD    = 6'h20;
  localparam logic [5:0] F_ADDU   = 6'h21;
  localparam logic [5:0] F_SUB    = 6'h22;
  localparam logic [5:0] F_SUBU   = 6'h23;
  localparam logic [5:0] F_AND    = 6'h24;
  localparam logic [5:0] F_OR     = 6'h25;
  localparam logic [5:0] F_SLT    = 6'h2A;
  localparam logic [5:0] F_SLTU   = 6'h2B;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BEQ  = 2'b01,
    BR_BNE  = 2'b10,
    BR_BGTZ = 2'b11
  } br_type_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } state_e;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       ext_op;
    logic [3:0] alu_ctr;
    logic       mem_to_reg;
    logic       mem_wr;
    logic       reg_wr;
    br_type_e   br_type;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_ZERO = '{reg_dst: 1'b0, alu_src: 1'b0, ext_op: 1'b0,
                                  alu_ctr: 4'b0000, mem_to_reg: 1'b0, mem_wr: 1'b0,
                                  reg_wr: 1'b0, br_type: BR_NONE, illegal: 1'b0};

  localparam ctrl_t CTRL_ILLEGAL = '{reg_dst: 1'b0, alu_src: 1'b0, ext_op: 1'b0,
                                     alu_ctr: 4'b0000, mem_to_reg: 1'b0, mem_wr: 1'b0,
                                     reg_wr: 1'b0, br_type: BR_NONE, illegal: 1'b1};

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct to control-bundle mapping; writes to register 0
// are suppressed so that all-zero words behave as NOPs.
module ctrl_decode
  import cpu_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  input  logic [4:0] i_rt,
  input  logic [4:0] i_rd,
  output ctrl_t      o_ctrl
);

  ctrl_t      w_raw;
  logic [4:0] w_dest;

  always_comb begin
    // NOTE: every field defaults first so no path through the cases infers a latch.
    w_raw = CTRL_ZERO;
    case (i_opcode)
      OP_RTYPE: begin
        w_raw.reg_dst = 1'b1;
        w_raw.reg_wr  = 1'b1;
        case (i_funct)
          F_ADD, F_ADDU: w_raw.alu_ctr = ALU_ADD;
          F_SUB, F_SUBU: w_raw.alu_ctr = ALU_SUB;
          F_AND:         w_raw.alu_ctr = ALU_AND;
          F_OR:          w_raw.alu_ctr = ALU_OR;
          F_SLT:         w_raw.alu_ctr = ALU_SLT;
          F_SLTU:        w_raw.alu_ctr = ALU_SLTU;
          F_SLL:         w_raw.alu_ctr = ALU_SLL;
          default:       w_raw = CTRL_ILLEGAL;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        w_raw.alu_src = 1'b1;
        w_raw.ext_op  = 1'b1;
        w_raw.reg_wr  = 1'b1;
        w_raw.alu_ctr = ALU_ADD;
      end
      OP_ORI: begin
        w_raw.alu_src = 1'b1;
        w_raw.reg_wr  = 1'b1;
        w_raw.alu_ctr = ALU_OR;
      end
      OP_LW: begin
        w_raw.alu_src    = 1'b1;
        w_raw.ext_op     = 1'b1;
        w_raw.mem_to_reg = 1'b1;
        w_raw.reg_wr     = 1'b1;
        w_raw.alu_ctr    = ALU_ADD;
      end
      OP_SW: begin
        w_raw.alu_src = 1'b1;
        w_raw.ext_op  = 1'b1;
        w_raw.mem_wr  = 1'b1;
        w_raw.alu_ctr = ALU_ADD;
      end
      OP_BEQ, OP_BNE, OP_BGTZ: begin
        w_raw.ext_op  = 1'b1;
        w_raw.alu_ctr = ALU_SUB;
        w_raw.br_type = (i_opcode == OP_BEQ) ? BR_BEQ :
                        (i_opcode == OP_BNE) ? BR_BNE : BR_BGTZ;
      end
      default: w_raw = CTRL_ILLEGAL;
    endcase
  end

  assign w_dest = w_raw.reg_dst ? i_rd : i_rt;

  always_comb begin
    o_ctrl = w_raw;
    if (w_dest == 5'd0) o_ctrl.reg_wr = 1'b0;
  end

endmodule

// File: rtl/if_id_decode.sv
// IF/ID stage: registers the fetched word, decodes controls, squashes the branch
// shadow and counts decoded instructions. ILLEGAL_TRAP_EN makes illegal sticky.
module if_id_decode
  import cpu_pkg::*;
#(
  parameter logic SQUASH_BR = 1'b1,
  parameter int   CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      inst,
  input  logic             inst_valid,
  input  logic             stall,
  input  logic             flush,
  output logic             valid,
  output logic [5:0]       opcode,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [4:0]       shamt,
  output logic [5:0]       funct,
  output logic [15:0]      imm16,
  output logic             reg_dst,
  output logic             alu_src,
  output logic             ext_op,
  output logic [3:0]       alu_ctr,
  output logic             mem_to_reg,
  output logic             mem_wr,
  output logic             reg_wr,
  output logic [1:0]       br_type,
  output logic             pc_sel,
  output logic             illegal,
  output logic [CNT_W-1:0] dec_count
);

  state_e           r_state;
  logic [31:0]      r_inst;
  logic             r_valid;
  ctrl_t            r_ctrl;
  logic             r_pc_sel;
  logic [CNT_W-1:0] r_count;
  ctrl_t            w_ctrl;
  logic             w_trap;
  logic             w_accept;

  ctrl_decode u_ctrl_decode (
    .i_opcode (inst[31:26]),
    .i_funct  (inst[5:0]),
    .i_rt     (inst[20:16]),
    .i_rd     (inst[15:11]),
    .o_ctrl   (w_ctrl)
  );

  assign w_accept = inst_valid && !stall && !flush;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments and a reset sampled on the edge.
    if (!rst_n) begin
      r_state  <= ST_RUN;
      r_inst   <= '0;
      r_valid  <= 1'b0;
      r_ctrl   <= CTRL_ZERO;
      r_pc_sel <= 1'b0;
      r_count  <= '0;
    end else if (flush || w_trap) begin
      r_state  <= ST_RUN;
      r_valid  <= 1'b0;
      r_ctrl   <= CTRL_ZERO;
      r_pc_sel <= 1'b0;
    end else if (!stall) begin
      r_inst <= inst;
      if (inst_valid && r_state == ST_SQUASH) begin
        // Branch shadow: the word is dropped and never counted.
        r_state  <= ST_RUN;
        r_valid  <= 1'b0;
        r_ctrl   <= CTRL_ZERO;
        r_pc_sel <= 1'b0;
      end else if (inst_valid) begin
        r_valid  <= 1'b1;
        r_ctrl   <= w_ctrl;
        r_pc_sel <= (w_ctrl.br_type != BR_NONE);
        r_count  <= r_count + CNT_W'(1);
        if (SQUASH_BR && w_ctrl.br_type != BR_NONE) r_state <= ST_SQUASH;
      end else begin
        r_valid  <= 1'b0;
        r_ctrl   <= CTRL_ZERO;
        r_pc_sel <= 1'b0;
      end
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic r_trap;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_trap <= 1'b0;
    end else if (w_accept && r_state == ST_RUN && w_ctrl.illegal) begin
      r_trap <= 1'b1;
    end
  end

  assign w_trap  = r_trap;
  assign illegal = r_ctrl.illegal | r_trap;
`else
  assign w_trap  = 1'b0;
  assign illegal = r_ctrl.illegal;
`endif

  assign valid      = r_valid;
  assign opcode     = r_inst[31:26];
  assign rs         = r_inst[25:21];
  assign rt         = r_inst[20:16];
  assign rd         = r_inst[15:11];
  assign shamt      = r_inst[10:6];
  assign funct      = r_inst[5:0];
  assign imm16      = r_inst[15:0];
  assign reg_dst    = r_ctrl.reg_dst;
  assign alu_src    = r_ctrl.alu_src;
  assign ext_op     = r_ctrl.ext_op;
  assign alu_ctr    = r_ctrl.alu_ctr;
  assign mem_to_reg = r_ctrl.mem_to_reg;
  assign mem_wr     = r_ctrl.mem_wr;
  assign reg_wr     = r_ctrl.reg_wr;
  assign br_type    = r_ctrl.br_type;
  assign pc_sel     = r_pc_sel;
  assign dec_count  = r_count;

endmodule

// File: tb/tb_if_id_decode.sv
// Scoreboard bench for if_id_decode (default build: SQUASH_BR=1, no trap).
// Stimulus queues expected decodes; the monitor pops one per newly counted output.
module tb_if_id_decode;

  logic        clk = 1'b0;
  logic        rst_n, inst_valid, stall, flush;
  logic [31:0] inst;
  logic        valid, reg_dst, alu_src, ext_op, mem_to_reg, mem_wr, reg_wr, pc_sel, illegal;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16, dec_count;
  logic [3:0]  alu_ctr;
  logic [1:0]  br_type;

  always #5 clk = ~clk;

  if_id_decode dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .inst_valid(inst_valid),
    .stall(stall), .flush(flush), .valid(valid), .opcode(opcode), .rs(rs),
    .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm16(imm16),
    .reg_dst(reg_dst), .alu_src(alu_src), .ext_op(ext_op), .alu_ctr(alu_ctr),
    .mem_to_reg(mem_to_reg), .mem_wr(mem_wr), .reg_wr(reg_wr), .br_type(br_type),
    .pc_sel(pc_sel), .illegal(illegal), .dec_count(dec_count)
  );

  // Control bundle order: reg_dst alu_src ext_op alu_ctr[4] mem_to_reg mem_wr reg_wr br_type[2] illegal
  logic [12:0] w_ctl;
  assign w_ctl = {reg_dst, alu_src, ext_op, alu_ctr, mem_to_reg, mem_wr, reg_wr, br_type, illegal};

  typedef struct {
    logic [31:0] inst;
    logic [12:0] ctrl;
    logic        pc_sel;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_cnt  = '0;
  logic [15:0] prev_cnt = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one word for acceptance and queue what it must decode to.
  task automatic send(input logic [31:0] w, input logic [12:0] ctl, input logic ps);
    exp_t e;
    exp_cnt   = exp_cnt + 16'd1;
    e.inst    = w;
    e.ctrl    = ctl;
    e.pc_sel  = ps;
    e.cnt     = exp_cnt;
    sb_q.push_back(e);
    inst       = w;
    inst_valid = 1'b1;
    step();
  endtask

  // Monitor: every newly counted valid output is matched against the queue head.
  always @(negedge clk) begin
    if (valid === 1'b1 && dec_count !== prev_cnt) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_output", 64'(dec_count), 64'(prev_cnt));
      end else begin
        mon_e = sb_q.pop_front();
        check("fields", 64'({opcode, rs, rt, rd, shamt, funct}), 64'(mon_e.inst));
        check("imm16", 64'(imm16), 64'(mon_e.inst[15:0]));
        check("ctrl", 64'(w_ctl), 64'(mon_e.ctrl));
        check("pc_sel", 64'(pc_sel), 64'(mon_e.pc_sel));
        check("dec_count", 64'(dec_count), 64'(mon_e.cnt));
      end
    end
    prev_cnt = dec_count;
  end

  initial begin
    rst_n = 1'b0; inst = 32'h8C220004; inst_valid = 1'b1; stall = 1'b0; flush = 1'b0;
    step(); step();
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_ctrl", 64'(w_ctl), 64'd0);
    check("rst_fields", 64'({opcode, rs, rt, rd, shamt, funct}), 64'd0);
    check("rst_imm16", 64'(imm16), 64'd0);
    check("rst_pc_sel", 64'(pc_sel), 64'd0);
    check("rst_count", 64'(dec_count), 64'd0);
    rst_n = 1'b1;

    send(32'h8C220004, 13'b0_1_1_0010_1_0_1_00_0, 1'b0);   // lw r2,4(r1)
    send(32'h00221820, 13'b1_0_0_0010_0_0_1_00_0, 1'b0);   // add r3,r1,r2

    stall = 1'b1; inst = 32'hFC000000;
    repeat (3) begin
      step();
      check("stall_valid", 64'(valid), 64'd1);
      check("stall_rd", 64'(rd), 64'd3);
      check("stall_funct", 64'(funct), 64'h20);
      check("stall_ctrl", 64'(w_ctl), 64'(13'b1_0_0_0010_0_0_1_00_0));
      check("stall_count", 64'(dec_count), 64'd2);
    end
    stall = 1'b0; inst_valid = 1'b0;
    step();
    check("idle_valid", 64'(valid), 64'd0);
    check("idle_ctrl", 64'(w_ctl), 64'd0);

    send(32'h10220003, 13'b0_0_1_0110_0_0_0_01_0, 1'b1);   // beq r1,r2,3
    inst = 32'h34030005; inst_valid = 1'b1;                // ori in branch shadow
    step();
    check("squash_valid", 64'(valid), 64'd0);
    check("squash_ctrl", 64'(w_ctl), 64'd0);
    check("squash_pc_sel", 64'(pc_sel), 64'd0);
    check("squash_count", 64'(dec_count), 64'd3);
    send(32'hAC220008, 13'b0_1_1_0010_0_1_0_00_0, 1'b0);   // sw r2,8(r1)

    send(32'h34030005, 13'b0_1_0_0001_0_0_1_00_0, 1'b0);   // ori r3,r0,5
    flush = 1'b1; stall = 1'b1;
    step();
    check("flush_valid", 64'(valid), 64'd0);
    check("flush_ctrl", 64'(w_ctl), 64'd0);
    check("flush_count", 64'(dec_count), 64'd5);
    flush = 1'b0; stall = 1'b0;

    send(32'hFC000000, 13'b0_0_0_0000_0_0_0_00_1, 1'b0);   // unsupported opcode
    send(32'h8C220004, 13'b0_1_1_0010_1_0_1_00_0, 1'b0);   // lw after illegal
    send(32'h00000000, 13'b1_0_0_0011_0_0_0_00_0, 1'b0);   // NOP: sll to r0
    send(32'h20000007, 13'b0_1_1_0010_0_0_0_00_0, 1'b0);   // addi r0: write dropped
    send(32'h1C200010, 13'b0_0_1_0110_0_0_0_11_0, 1'b1);   // bgtz r1,16

    inst_valid = 1'b0;
    step();
    check("shadow_idle_valid", 64'(valid), 64'd0);
    rst_n = 1'b0;
    step();
    check("rst2_valid", 64'(valid), 64'd0);
    check("rst2_count", 64'(dec_count), 64'd0);
    check("rst2_ctrl", 64'(w_ctl), 64'd0);
    rst_n = 1'b1; exp_cnt = '0;
    send(32'h0022182B, 13'b1_0_0_1111_0_0_1_00_0, 1'b0);   // sltu: shadow cleared by reset

    inst_valid = 1'b0;
    step(); step();
    check("sb_drain", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
